hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the in-order core. Inspects the instruction

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, mispredict flushes and blocking
// in/out handshakes, driving the shared stall/flush lines beside decode.
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned IO_TIMEOUT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de_read_reg1,
  input  logic       de_read_reg2,
  input  logic [4:0] de_reg1_addr,
  input  logic [4:0] de_reg2_addr,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic       ex_data_in,
  input  logic       ex_data_out,
  input  logic       branch_wrong,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       stall,
  output logic       flush_ex,
  output logic       in_ready,
  output logic       out_valid,
  output logic       io_timeout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLoadWait = 2'd1,
    StInWait   = 2'd2,
    StOutWait  = 2'd3
  } state_e;

  localparam logic [3:0]  BubbleInit   = 4'(LOAD_BUBBLES - 1);
  localparam logic [15:0] TimeoutLimit = 16'(IO_TIMEOUT);
  localparam bit          MultiBubble  = (LOAD_BUBBLES > 1);
  localparam bit          TimeoutEn    = (IO_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [3:0]  bubble_q, bubble_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] wait_inc;
  logic        io_timeout_q, io_timeout_d;
  logic        load_use;
  logic        waiting;

  // x0 is never a real producer, so a load to it cannot create a hazard.
  assign load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                    ((de_read_reg1 && (de_reg1_addr == ex_write_reg)) ||
                     (de_read_reg2 && (de_reg2_addr == ex_write_reg)));

  assign waiting  = ((state_q == StInWait) && !in_valid) ||
                    ((state_q == StOutWait) && !out_ready);
  assign wait_inc = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      bubble_q     <= 4'd0;
      wait_q       <= 16'd0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bubble_q     <= bubble_d;
      wait_q       <= wait_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bubble_d     = bubble_q;
    wait_d       = wait_q;
    io_timeout_d = io_timeout_q;
    unique case (state_q)
      StRun: begin
        if (!branch_wrong) begin
          if (ex_data_in) begin
            if (!in_valid) begin
              state_d = StInWait;
              wait_d  = 16'd0;
            end
          end else if (ex_data_out) begin
            if (!out_ready) begin
              state_d = StOutWait;
              wait_d  = 16'd0;
            end
          end else if (load_use) begin
            bubble_d = BubbleInit;
            if (MultiBubble) state_d = StLoadWait;
          end
        end
      end
      StLoadWait: begin
        bubble_d = bubble_q - 4'd1;
        if (bubble_q == 4'd1) state_d = StRun;
      end
      StInWait: begin
        if (in_valid) state_d = StRun;
      end
      StOutWait: begin
        if (out_ready) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    // The wait keeps going past the limit; the flag only reports it.
    if (waiting) begin
      wait_d = wait_inc;
      if (TimeoutEn && (wait_inc == TimeoutLimit)) io_timeout_d = 1'b1;
    end
  end

  always_comb begin
    stall     = 1'b0;
    flush_ex  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (branch_wrong) begin
            flush_ex = 1'b1;
          end else if (ex_data_in) begin
            in_ready = 1'b1;
            stall    = !in_valid;
          end else if (ex_data_out) begin
            out_valid = 1'b1;
            stall     = !out_ready;
          end else if (load_use) begin
            stall    = 1'b1;
            flush_ex = 1'b1;
          end
        end
        StLoadWait: begin
          stall    = 1'b1;
          flush_ex = 1'b1;
        end
        StInWait: begin
          in_ready = 1'b1;
          stall    = !in_valid;
        end
        StOutWait: begin
          out_valid = 1'b1;
          stall     = !out_ready;
        end
        default: ;
      endcase
    end
  end

  assign io_timeout = io_timeout_q;
  assign state      = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 bubble + timeout 4, 3 bubbles + no timeout)
// share stimulus; expected output words go through a scoreboard checked on negedge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       de_read_reg1 = 1'b0, de_read_reg2 = 1'b0;
  logic [4:0] de_reg1_addr = 5'd0, de_reg2_addr = 5'd0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_write_reg = 5'd0;
  logic       ex_data_in = 1'b0, ex_data_out = 1'b0, branch_wrong = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;

  logic       stall_a, flush_a, ir_a, ov_a, to_a;
  logic [1:0] state_a;
  logic       stall_b, flush_b, ir_b, ov_b, to_b;
  logic [1:0] state_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(1), .IO_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst),
    .de_read_reg1(de_read_reg1), .de_read_reg2(de_read_reg2),
    .de_reg1_addr(de_reg1_addr), .de_reg2_addr(de_reg2_addr),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .ex_data_in(ex_data_in), .ex_data_out(ex_data_out), .branch_wrong(branch_wrong),
    .in_valid(in_valid), .out_ready(out_ready),
    .stall(stall_a), .flush_ex(flush_a), .in_ready(ir_a), .out_valid(ov_a),
    .io_timeout(to_a), .state(state_a)
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .IO_TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .de_read_reg1(de_read_reg1), .de_read_reg2(de_read_reg2),
    .de_reg1_addr(de_reg1_addr), .de_reg2_addr(de_reg2_addr),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .ex_data_in(ex_data_in), .ex_data_out(ex_data_out), .branch_wrong(branch_wrong),
    .in_valid(in_valid), .out_ready(out_ready),
    .stall(stall_b), .flush_ex(flush_b), .in_ready(ir_b), .out_valid(ov_b),
    .io_timeout(to_b), .state(state_b)
  );

  // Output word: {state[1:0], io_timeout, out_valid, in_ready, flush_ex, stall}
  localparam logic [6:0] IDLE       = 7'b00_0_0_0_0_0;
  localparam logic [6:0] TO         = 7'b00_1_0_0_0_0;
  localparam logic [6:0] RUN_BUB    = 7'b00_0_0_0_1_1;
  localparam logic [6:0] LW_BUB     = 7'b01_0_0_0_1_1;
  localparam logic [6:0] FLUSH      = 7'b00_0_0_0_1_0;
  localparam logic [6:0] IN_GO      = 7'b00_0_0_1_0_0;
  localparam logic [6:0] IN_STALL   = 7'b00_0_0_1_0_1;
  localparam logic [6:0] INW_STALL  = 7'b10_0_0_1_0_1;
  localparam logic [6:0] INW_GO     = 7'b10_0_0_1_0_0;
  localparam logic [6:0] OUT_GO     = 7'b00_0_1_0_0_0;
  localparam logic [6:0] OUT_STALL  = 7'b00_0_1_0_0_1;
  localparam logic [6:0] OUTW_STALL = 7'b11_0_1_0_0_1;
  localparam logic [6:0] OUTW_GO    = 7'b11_0_1_0_0_0;

  typedef struct {
    string      name;
    logic       rst;
    logic       rr1, rr2;
    logic [4:0] ra1, ra2;
    logic       mr;
    logic [4:0] wr;
    logic       din, dout, bw, iv, ordy;
    logic [6:0] ea, eb;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] ea, eb;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;
  int   compared = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input string name, input logic r, input logic rr1, rr2,
                              input logic [4:0] ra1, ra2, input logic mr,
                              input logic [4:0] wr, input logic din, dout, bw, iv, ordy,
                              input logic [6:0] ea, eb);
    vec_t v;
    v.name = name; v.rst = r; v.rr1 = rr1; v.rr2 = rr2; v.ra1 = ra1; v.ra2 = ra2;
    v.mr = mr; v.wr = wr; v.din = din; v.dout = dout; v.bw = bw; v.iv = iv;
    v.ordy = ordy; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t x;
    @(posedge clk);
    #1;
    rst = v.rst;
    de_read_reg1 = v.rr1; de_read_reg2 = v.rr2;
    de_reg1_addr = v.ra1; de_reg2_addr = v.ra2;
    ex_mem_read = v.mr; ex_write_reg = v.wr;
    ex_data_in = v.din; ex_data_out = v.dout; branch_wrong = v.bw;
    in_valid = v.iv; out_ready = v.ordy;
    x.name = v.name; x.ea = v.ea; x.eb = v.eb;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared += 2;
      if ({state_a, to_a, ov_a, ir_a, flush_a, stall_a} !== e.ea) begin
        mismatched++;
        $display("FAIL %s lb1: got %b want %b", e.name,
                 {state_a, to_a, ov_a, ir_a, flush_a, stall_a}, e.ea);
      end
      if ({state_b, to_b, ov_b, ir_b, flush_b, stall_b} !== e.eb) begin
        mismatched++;
        $display("FAIL %s lb3: got %b want %b", e.name,
                 {state_b, to_b, ov_b, ir_b, flush_b, stall_b}, e.eb);
      end
    end
    if (!rst && branch_wrong && (state_a != 2'd0 || state_b != 2'd0)) begin
      mismatched++;
      $display("FAIL branch_outside_run: state_a %0d state_b %0d required 0", state_a, state_b);
    end
    if ((ir_a && ov_a) || (ir_b && ov_b)) begin
      mismatched++;
      $display("FAIL in_out_exclusive: in_ready and out_valid both 1, required not both");
    end
  end

  initial begin
    //                       rst rr1 rr2 ra1 ra2 mr wr din dout bw iv ordy ea eb
    tbl.push_back(mk("reset",       1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("idle",        0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("lu_rs1",      0, 1, 1, 5'd5, 5'd1, 1, 5'd5, 0, 0, 0, 0, 0,
                     RUN_BUB, RUN_BUB));
    tbl.push_back(mk("lu_rs1_b2",   0, 1, 1, 5'd5, 5'd1, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, LW_BUB));
    tbl.push_back(mk("lu_rs1_b3",   0, 1, 1, 5'd5, 5'd1, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, LW_BUB));
    tbl.push_back(mk("lu_rs1_done", 0, 1, 1, 5'd5, 5'd1, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("lu_rs2",      0, 1, 1, 5'd3, 5'd7, 1, 5'd7, 0, 0, 0, 0, 0,
                     RUN_BUB, RUN_BUB));
    tbl.push_back(mk("lu_rs2_b2",   0, 1, 1, 5'd3, 5'd7, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, LW_BUB));
    tbl.push_back(mk("lu_rs2_b3",   0, 1, 1, 5'd3, 5'd7, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, LW_BUB));
    tbl.push_back(mk("lu_rs2_done", 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("lw_x0",       0, 1, 1, 5'd0, 5'd1, 1, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("no_read_flg", 0, 0, 0, 5'd5, 5'd5, 1, 5'd5, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("not_load",    0, 1, 1, 5'd5, 5'd5, 0, 5'd5, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("br_over_lu",  0, 1, 1, 5'd5, 5'd1, 1, 5'd5, 0, 0, 1, 0, 0, FLUSH, FLUSH));
    tbl.push_back(mk("br_over_io",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 0, 0, FLUSH, FLUSH));
    tbl.push_back(mk("after_br",    0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));
    tbl.push_back(mk("out_ready",   0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1, OUT_GO, OUT_GO));
    tbl.push_back(mk("in_valid",    0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1, 0, IN_GO, IN_GO));
    tbl.push_back(mk("in_over_lu",  0, 1, 0, 5'd5, 5'd0, 1, 5'd5, 1, 0, 0, 1, 0, IN_GO, IN_GO));
    tbl.push_back(mk("idle2",       0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // in: in_valid low for 3 cycles, then the single consuming handshake
    step(mk("in_stall",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, IN_STALL, IN_STALL));
    for (int k = 0; k < 2; k++)
      step(mk("in_wait", 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, INW_STALL, INW_STALL));
    step(mk("in_done",   0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1, 0, INW_GO, INW_GO));
    step(mk("in_after",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));

    // out: short wait, well under the timeout
    step(mk("out_stall", 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, OUT_STALL, OUT_STALL));
    step(mk("out_wait",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, OUTW_STALL, OUTW_STALL));
    step(mk("out_done",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1, OUTW_GO, OUTW_GO));
    step(mk("out_after", 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));

    // out_ready low for 10 wait cycles: flag rises after the 4th, then stays
    step(mk("to_issue",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, OUT_STALL, OUT_STALL));
    for (int k = 1; k <= 10; k++)
      step(mk($sformatf("to_wait%0d", k), 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0,
              (k > 4) ? (OUTW_STALL | TO) : OUTW_STALL, OUTW_STALL));
    step(mk("to_done",   0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1, OUTW_GO | TO, OUTW_GO));
    step(mk("to_sticky", 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, TO, IDLE));

    // reset pulse while parked in IN_WAIT
    step(mk("rw_stall",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, IN_STALL | TO, IN_STALL));
    step(mk("rw_wait",   0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0,
            INW_STALL | TO, INW_STALL));
    step(mk("rw_rst1",   1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, IDLE, IDLE));
    step(mk("rw_rst2",   1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1, 0, IDLE, IDLE));
    step(mk("rw_after",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, IDLE));
    step(mk("rw_in_go",  0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1, 0, IN_GO, IN_GO));

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
